// File: rtl/alu_in_responder_pkg.sv
// Shared opcode/state types and per-operation latencies for the ALU responder.
package alu_in_pkg_hdl;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_RST = 3'b111
  } alu_in_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_in_state_t;

  localparam int LAT_ADD = 2;
  localparam int LAT_AND = 1;
  localparam int LAT_XOR = 1;
  localparam int LAT_MUL = 4;

  localparam int CNT_W = 2;

  // Down-counter load value is latency minus one; unknown ops never start a count.
  function automatic logic [CNT_W-1:0] countLoad(input alu_in_op_t op);
    case (op)
      OP_ADD:  countLoad = CNT_W'(LAT_ADD - 1);
      OP_AND:  countLoad = CNT_W'(LAT_AND - 1);
      OP_XOR:  countLoad = CNT_W'(LAT_XOR - 1);
      OP_MUL:  countLoad = CNT_W'(LAT_MUL - 1);
      default: countLoad = '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_in_responder_mul_pipe.sv
// Three-stage registered unsigned multiplier: operands, raw product, output.
module alu_in_mul_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load,
  input  logic [DATA_WIDTH-1:0]     i_a,
  input  logic [DATA_WIDTH-1:0]     i_b,
  output logic [2*DATA_WIDTH-1:0]   o_prod
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [PROD_W-1:0]     r_stage2;
  logic [PROD_W-1:0]     r_stage3;

  // Operands are held between loads, so the later stages keep presenting the same product.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_stage2 <= '0;
      r_stage3 <= '0;
    end else begin
      if (i_load) begin
        r_a <= i_a;
        r_b <= i_b;
      end
      r_stage2 <= PROD_W'(r_a) * PROD_W'(r_b);
      r_stage3 <= r_stage2;
    end
  end

  assign o_prod = r_stage3;

endmodule

// File: rtl/alu_in_responder.sv
// Valid/ready ALU responder: single-cycle and/xor, two-cycle add, four-cycle pipelined multiply.
module alu_in_responder
  import alu_in_pkg_hdl::*;
#(
  parameter  int DATA_WIDTH   = 8,
  localparam int RESULT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [2:0]              i_op,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  output logic                    o_ready,
  output logic                    o_done,
  output logic [RESULT_WIDTH-1:0] o_result
);

  alu_in_state_t           r_state;
  alu_in_state_t           w_nextState;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_nextCount;
  logic                    r_done;
  logic                    w_nextDone;
  logic [RESULT_WIDTH-1:0] r_result;
  logic [RESULT_WIDTH-1:0] w_nextResult;
  alu_in_op_t              r_op;
  alu_in_op_t              w_nextOp;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [DATA_WIDTH-1:0]   w_nextA;
  logic [DATA_WIDTH-1:0]   w_nextB;

  alu_in_op_t              w_inOp;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_mulLoad;
  logic [RESULT_WIDTH-1:0] w_mulProd;
  logic [RESULT_WIDTH-1:0] w_busyResult;

  assign w_inOp    = alu_in_op_t'(i_op);
  assign w_ready   = (r_state == ST_IDLE);
  assign w_accept  = i_valid && w_ready;
  assign w_mulLoad = w_accept && (w_inOp == OP_MUL);

  alu_in_mul_pipe #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mulPipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_mulLoad),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_prod (w_mulProd)
  );

  assign w_busyResult = (r_op == OP_MUL) ? w_mulProd
                                         : RESULT_WIDTH'(r_a) + RESULT_WIDTH'(r_b);

  // Single-cycle ops finish on their acceptance edge, so the live inputs are the captured operands.
  always_comb begin
    w_nextState  = r_state;
    w_nextCount  = r_count;
    w_nextDone   = 1'b0;
    w_nextResult = r_result;
    w_nextOp     = r_op;
    w_nextA      = r_a;
    w_nextB      = r_b;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_inOp)
            OP_AND: begin
              w_nextDone   = 1'b1;
              w_nextResult = RESULT_WIDTH'(i_a & i_b);
            end
            OP_XOR: begin
              w_nextDone   = 1'b1;
              w_nextResult = RESULT_WIDTH'(i_a ^ i_b);
            end
            OP_ADD, OP_MUL: begin
              w_nextState = ST_BUSY;
              w_nextCount = countLoad(w_inOp);
              w_nextOp    = w_inOp;
              w_nextA     = i_a;
              w_nextB     = i_b;
            end
            OP_RST: begin
              w_nextResult = '0;
            end
            default: begin
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (r_count == CNT_W'(1)) begin
          w_nextState  = ST_IDLE;
          w_nextCount  = '0;
          w_nextDone   = 1'b1;
          w_nextResult = w_busyResult;
        end else begin
          w_nextCount = r_count - CNT_W'(1);
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCount = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_op     <= OP_NOP;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_state  <= w_nextState;
      r_count  <= w_nextCount;
      r_done   <= w_nextDone;
      r_result <= w_nextResult;
      r_op     <= w_nextOp;
      r_a      <= w_nextA;
      r_b      <= w_nextB;
    end
  end

  assign o_ready  = w_ready;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_alu_in_responder.sv
// Self-checking bench: directed vector table, corner sequences, and random traffic vs a timeline model.
module tb_alu_in_responder;

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] XOR = 3'b011;
  localparam logic [2:0] MUL = 3'b100;
  localparam logic [2:0] RSTOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [2:0]  op = NOP;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        ready;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute edge number at which the pending op completes.
  int          edgeNo = 0;
  int          doneEdge = -1;
  logic [15:0] pendingVal = '0;
  logic [15:0] mResult = '0;
  logic        mDone = 1'b0;
  logic        mReady = 1'b1;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expResult;
    int          expLatency;
  } vec_t;

  vec_t vecs[10];

  alu_in_responder #(.DATA_WIDTH(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (valid),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_ready  (ready),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  function automatic int latencyOf(input logic [2:0] o);
    case (o)
      ADD:     return 2;
      AND:     return 1;
      XOR:     return 1;
      MUL:     return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] refValue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int unsigned ux = x;
    int unsigned uy = y;
    case (o)
      ADD:     return 16'(ux + uy);
      AND:     return 16'(ux & uy);
      XOR:     return 16'(ux ^ uy);
      MUL:     return 16'(ux * uy);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edgeNo);
    end
  endtask

  task automatic modelEdge();
    int k = edgeNo;
    int lat;
    mDone = 1'b0;
    if (rst) begin
      doneEdge = -1;
      mResult  = '0;
    end else if (doneEdge == k) begin
      mDone   = 1'b1;
      mResult = pendingVal;
    end else if (doneEdge < k && valid) begin
      lat = latencyOf(op);
      if (lat > 0) begin
        doneEdge   = k + lat - 1;
        pendingVal = refValue(op, a, b);
        if (lat == 1) begin
          mDone   = 1'b1;
          mResult = pendingVal;
        end
      end else if (op == RSTOP) begin
        mResult = '0;
      end
    end
    edgeNo++;
    mReady = (doneEdge < edgeNo);
  endtask

  task automatic checkOutput();
    check("ready", 32'(ready), 32'(mReady));
    check("done", 32'(done), 32'(mDone));
    check("result", 32'(result), 32'(mResult));
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [7:0] x,
                               input logic [7:0] y, input logic r);
    valid = v;
    op    = o;
    a     = x;
    b     = y;
    rst   = r;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic runVector(input vec_t v);
    int lat = 1;
    applyStimulus(1'b1, v.op, v.a, v.b, 1'b0);
    while (!done && lat < 10) begin
      applyStimulus(1'b0, NOP, 8'h00, 8'h00, 1'b0);
      lat++;
    end
    check({v.name, "_done"}, 32'(done), 32'd1);
    check({v.name, "_latency"}, 32'(lat), 32'(v.expLatency));
    check({v.name, "_result"}, 32'(result), 32'(v.expResult));
    applyStimulus(1'b0, NOP, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    vecs[0] = '{"addCarry", ADD, 8'hFF, 8'h01, 16'h0100, 2};
    vecs[1] = '{"mulMax",   MUL, 8'hFF, 8'hFF, 16'hFE01, 4};
    vecs[2] = '{"andMix",   AND, 8'hF0, 8'h3C, 16'h0030, 1};
    vecs[3] = '{"xorMix",   XOR, 8'hF0, 8'h3C, 16'h00CC, 1};
    vecs[4] = '{"addMax",   ADD, 8'hFF, 8'hFF, 16'h01FE, 2};
    vecs[5] = '{"mulZero",  MUL, 8'h00, 8'h7B, 16'h0000, 4};
    vecs[6] = '{"mulSmall", MUL, 8'h02, 8'h03, 16'h0006, 4};
    vecs[7] = '{"andOnes",  AND, 8'hFF, 8'hFF, 16'h00FF, 1};
    vecs[8] = '{"xorAlt",   XOR, 8'hAA, 8'h55, 16'h00FF, 1};
    vecs[9] = '{"addSmall", ADD, 8'h12, 8'h34, 16'h0046, 2};

    applyStimulus(1'b1, MUL, 8'h05, 8'h05, 1'b1);
    applyStimulus(1'b0, NOP, 8'h00, 8'h00, 1'b1);
    check("resetReady", 32'(ready), 32'd1);
    check("resetDone", 32'(done), 32'd0);
    check("resetResult", 32'(result), 32'd0);

    foreach (vecs[i]) runVector(vecs[i]);

    // mul FF*FF: three busy cycles then done
    applyStimulus(1'b1, MUL, 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("mulBusyReady", 32'(ready), 32'd0);
      check("mulBusyDone", 32'(done), 32'd0);
      applyStimulus(1'b0, NOP, 8'h00, 8'h00, 1'b0);
    end
    check("mulDone", 32'(done), 32'd1);
    check("mulResult", 32'(result), 32'h0000FE01);

    // back-to-back and then xor on consecutive done pulses
    applyStimulus(1'b1, AND, 8'hF0, 8'h3C, 1'b0);
    check("b2bAndDone", 32'(done), 32'd1);
    check("b2bAndResult", 32'(result), 32'h00000030);
    check("b2bAndReady", 32'(ready), 32'd1);
    applyStimulus(1'b1, XOR, 8'hF0, 8'h3C, 1'b0);
    check("b2bXorDone", 32'(done), 32'd1);
    check("b2bXorResult", 32'(result), 32'h000000CC);
    applyStimulus(1'b0, NOP, 8'h00, 8'h00, 1'b0);
    check("b2bQuiet", 32'(done), 32'd0);

    // add held valid during a busy mul
    applyStimulus(1'b1, MUL, 8'h02, 8'h03, 1'b0);
    repeat (3) applyStimulus(1'b1, ADD, 8'h01, 8'h01, 1'b0);
    check("heldMulDone", 32'(done), 32'd1);
    check("heldMulResult", 32'(result), 32'h00000006);
    applyStimulus(1'b1, ADD, 8'h01, 8'h01, 1'b0);
    check("heldAddBusy", 32'(ready), 32'd0);
    check("heldAddNoDone", 32'(done), 32'd0);
    applyStimulus(1'b0, NOP, 8'h00, 8'h00, 1'b0);
    check("heldAddDone", 32'(done), 32'd1);
    check("heldAddResult", 32'(result), 32'h00000002);

    // reset two edges into a mul aborts it
    applyStimulus(1'b1, MUL, 8'h09, 8'h07, 1'b0);
    applyStimulus(1'b0, NOP, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, ADD, 8'h01, 8'h01, 1'b1);
    check("abortReady", 32'(ready), 32'd1);
    check("abortDone", 32'(done), 32'd0);
    check("abortResult", 32'(result), 32'd0);
    applyStimulus(1'b1, AND, 8'h0F, 8'h0A, 1'b0);
    check("postResetAccept", 32'(result), 32'h0000000A);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, NOP, 8'h00, 8'h00, 1'b0);
      check("abortNoLateDone", 32'(done), 32'd0);
    end

    // rst_op clears result without done; opcode 101 is ignored
    applyStimulus(1'b1, MUL, 8'h02, 8'h03, 1'b0);
    repeat (3) applyStimulus(1'b0, NOP, 8'h00, 8'h00, 1'b0);
    check("preRstOpResult", 32'(result), 32'h00000006);
    applyStimulus(1'b1, RSTOP, 8'h00, 8'h00, 1'b0);
    check("rstOpResult", 32'(result), 32'd0);
    check("rstOpDone", 32'(done), 32'd0);
    applyStimulus(1'b1, XOR, 8'h0F, 8'h01, 1'b0);
    applyStimulus(1'b1, 3'b101, 8'h33, 8'h44, 1'b0);
    check("op101Done", 32'(done), 32'd0);
    check("op101Ready", 32'(ready), 32'd1);
    check("op101Result", 32'(result), 32'h0000000E);
    applyStimulus(1'b1, 3'b110, 8'h33, 8'h44, 1'b0);
    check("op110Done", 32'(done), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom % 4) != 0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    ($urandom % 60) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_in_responder.md
ALU_IN_RESPONDER -- requirements
Module: alu_in_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the operand width.
REQ-002 SHALL have parameter RESULT_WIDTH, default 2*DATA_WIDTH, the result width; it is not overridable independently of DATA_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid  input  1  initiator presents an operation.
REQ-006 op  input  3  opcode: no_op=000, add_op=001, and_op=010, xor_op=011, mul_op=100, rst_op=111.
REQ-007 a  input  DATA_WIDTH  operand A.
REQ-008 b  input  DATA_WIDTH  operand B.
REQ-009 ready  output  1  responder can accept an operation this cycle.
REQ-010 done  output  1  single-cycle pulse; result is valid.
REQ-011 result  output  RESULT_WIDTH  last completed result.

Function
REQ-012 An operation SHALL be accepted on a rising edge where valid=1 and ready=1; valid while ready=0 SHALL be ignored, not queued.
REQ-013 op, a and b SHALL be captured at acceptance; later input changes SHALL NOT affect an in-flight operation.
REQ-014 State machine SHALL have states IDLE and BUSY; ready=1 in IDLE, ready=0 in BUSY, except as stated in REQ-017.
REQ-015 Latency L, counted from the acceptance edge N to the edge that raises done, SHALL be: and_op=1, xor_op=1, add_op=2, mul_op=4; done SHALL be high for the cycle after edge N+L-1 (the cycle following edge N+L-1), for exactly one cycle.
REQ-016 IDLE to BUSY on acceptance of add/and/xor/mul; a down-counter loaded with L-1; BUSY to IDLE on the edge where done is raised.
REQ-017 ready SHALL be 1 in the cycle done=1, allowing a back-to-back acceptance that same cycle with no idle gap.
REQ-018 add_op result SHALL be a+b zero-extended, with the carry in bit DATA_WIDTH; and_op/xor_op results SHALL be zero-extended; mul_op SHALL be the full unsigned product.
REQ-019 result SHALL update on the same edge that raises done, and SHALL hold until the next done or reset.
REQ-020 no_op SHALL be accepted with no state change and no done.
REQ-021 rst_op SHALL be accepted only in IDLE, SHALL clear result to 0 on the next edge, and SHALL NOT produce done.
REQ-022 Opcodes 101 and 110 SHALL be treated as no_op.
REQ-023 Arithmetic SHALL be unsigned; there is no overflow condition because RESULT_WIDTH holds every result.

Reset
REQ-024 While rst=1 at a rising edge: state=IDLE, counter=0, ready=1, done=0, result=0.
REQ-025 rst asserted mid-operation SHALL abort the operation; no done SHALL be produced for it, and the first cycle after reset is released SHALL accept a new operation.
REQ-026 rst SHALL take priority over simultaneous valid.

Structure
REQ-027 Shared package alu_in_pkg_hdl SHALL hold the opcode enum type alu_in_op_t and the per-op latency constants.
REQ-028 The multiplier SHALL be a sub-module, alu_in_mul_pipe: DATA_WIDTH-parameterised, a 3-stage registered product, and cleared by rst.
REQ-029 Add/and/xor SHALL be computed in the top module from the captured operands.

Verification
REQ-030 add_op a=0xFF b=0x01 accepted at edge N -> done=1 only in the cycle after edge N+1, result=0x0100.
REQ-031 mul_op a=0xFF b=0xFF -> done 4 edges after acceptance, result=0xFE01; ready=0 for the 3 intervening cycles.
REQ-032 and_op 0xF0,0x3C then xor_op 0xF0,0x3C presented back-to-back using REQ-017 -> results 0x0030 then 0x00CC on consecutive done pulses.
REQ-033 valid=1 add_op 0x01,0x01 held during a BUSY mul_op 0x02,0x03 -> one done with result=0x0006, then the add is accepted on the done cycle -> result=0x0002.
REQ-034 rst pulsed 2 edges after accepting mul_op -> no done, result=0, ready=1 the next cycle.
REQ-035 rst_op after result=0x0006 -> result=0x0000 on the next edge, done stays 0; opcode 101 -> no response.
